prod_round_sat: RTL and testbench

- Downstream stage of the 32x32 unsigned multiplier in the DSP path.
- Takes the raw 64-bit product and applies a fixed-point rescale: right shift by FRAC_BITS, round half-up, saturate to OUT_W.
- Returns a sample-width result to the voice/mixer datapath.
- Two-stage pipeline with valid/ready handshake on both sides; full throughput; backpressure-safe.

---
 rtl/prod_round_sat_pkg.sv | 21 ++
 rtl/prod_round_sat.sv | 119 +++++++++++
 tb/tb_prod_round_sat.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/prod_round_sat_pkg.sv
// Shared DSP constants and helpers for the product rescale stage.
// Holds the multiplier product width, default Q-format and round-constant helper.
package prod_round_sat_pkg;

    localparam int PROD_W        = 64;
    localparam int SUM_W         = PROD_W + 1;
    localparam int DEF_FRAC_BITS = 32;
    localparam int DEF_OUT_W     = 32;
    localparam int SAT_CNT_W     = 16;

    // Half an output LSB, added ahead of the shift to get round-half-up.
    function automatic logic [SUM_W-1:0] round_const(input int frac_bits, input int rnd);
        logic [SUM_W-1:0] one;
        one = SUM_W'(1);
        if (rnd != 0 && frac_bits > 0) begin
            return one << (frac_bits - 1);
        end
        return '0;
    endfunction

endpackage

// File: rtl/prod_round_sat.sv
// Rescales a 64-bit unsigned product: round half-up, shift by FRAC_BITS, saturate to OUT_W.
// Optional saturation counter enabled by defining PROD_ROUND_SAT_STATS_EN.
module prod_round_sat
    import prod_round_sat_pkg::*;
#(
    parameter int FRAC_BITS = DEF_FRAC_BITS,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int ROUND     = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_sat
`ifdef PROD_ROUND_SAT_STATS_EN
    ,
    input  logic                 sat_clr,
    output logic [SAT_CNT_W-1:0] sat_count
`endif
);

    localparam logic [SUM_W-1:0] RND = round_const(FRAC_BITS, ROUND);

    logic             s1_valid_q, s1_valid_d;
    logic [SUM_W-1:0] s1_sum_q,   s1_sum_d;
    logic             s2_valid_q, s2_valid_d;
    logic [OUT_W-1:0] s2_data_q,  s2_data_d;
    logic             s2_sat_q,   s2_sat_d;

    logic             s2_adv;
    logic [SUM_W-1:0] in_sum;
    logic [SUM_W-1:0] q;
    logic [SUM_W-1:0] q_hi;
    logic             q_ovf;

    // The extra sum bit keeps the rounding carry out of bit 63 so all-ones saturates.
    assign in_sum = {1'b0, in_data} + RND;
    assign q      = s1_sum_q >> FRAC_BITS;
    assign q_hi   = q >> OUT_W;
    assign q_ovf  = |q_hi;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sum_d   = s1_sum_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_sat_d   = s2_sat_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sum_d = in_sum;
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_sat_d  = q_ovf;
                s2_data_d = q_ovf ? '1 : q[OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_sat_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sum_q   <= s1_sum_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_sat_q   <= s2_sat_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_sat   = s2_sat_q;

`ifdef PROD_ROUND_SAT_STATS_EN
    logic [SAT_CNT_W-1:0] sat_count_q, sat_count_d;
    logic                 sat_inc;

    assign sat_inc = s2_valid_q && out_ready && s2_sat_q;

    // Clear takes priority over a coincident increment; the count sticks at full scale.
    always_comb begin
        sat_count_d = sat_count_q;
        if (sat_clr) begin
            sat_count_d = '0;
        end else if (sat_inc && sat_count_q != '1) begin
            sat_count_d = sat_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sat_count_q <= '0;
        end else begin
            sat_count_q <= sat_count_d;
        end
    end

    assign sat_count = sat_count_q;
`endif

endmodule

// File: tb/tb_prod_round_sat.sv
// Directed bench for prod_round_sat: three parameterisations share one stimulus stream.
// Saturation-counter checks run when PROD_ROUND_SAT_STATS_EN is defined.
module tb_prod_round_sat;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] in_data;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_sat;
    logic [31:0] a_out_data;
    logic        b_in_ready, b_out_valid, b_out_sat;
    logic [31:0] b_out_data;
    logic        c_in_ready, c_out_valid, c_out_sat;
    logic [15:0] c_out_data;

    int n_checks = 0;
    int n_errors = 0;

`ifdef PROD_ROUND_SAT_STATS_EN
    logic        sat_clr;
    logic [15:0] a_sat_count, b_sat_count, c_sat_count;
`endif

    prod_round_sat #(.FRAC_BITS(32), .OUT_W(32), .ROUND(1)) dut_a (
        .clk(clk), .reset_n(rst_n),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .out_sat(a_out_sat)
`ifdef PROD_ROUND_SAT_STATS_EN
        , .sat_clr(sat_clr), .sat_count(a_sat_count)
`endif
    );

    prod_round_sat #(.FRAC_BITS(32), .OUT_W(32), .ROUND(0)) dut_b (
        .clk(clk), .reset_n(rst_n),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .out_sat(b_out_sat)
`ifdef PROD_ROUND_SAT_STATS_EN
        , .sat_clr(sat_clr), .sat_count(b_sat_count)
`endif
    );

    prod_round_sat #(.FRAC_BITS(0), .OUT_W(16), .ROUND(1)) dut_c (
        .clk(clk), .reset_n(rst_n),
        .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data),
        .out_valid(c_out_valid), .out_ready(out_ready),
        .out_data(c_out_data), .out_sat(c_out_sat)
`ifdef PROD_ROUND_SAT_STATS_EN
        , .sat_clr(sat_clr), .sat_count(c_sat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got still running expected finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One item through an empty pipeline with out_ready held high.
    task automatic run_vec(input logic [63:0] d,
                           input logic [31:0] ea, input logic sa,
                           input logic [31:0] eb, input logic sb,
                           input logic [15:0] ec, input logic sc);
        int lat;
        check("vec_in_ready", 64'(a_in_ready), 64'(1));
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!a_out_valid && lat < 6) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("vec in=%016h lat=%0d a=%08h/%0b b=%08h/%0b c=%04h/%0b",
                 d, lat, a_out_data, a_out_sat, b_out_data, b_out_sat, c_out_data, c_out_sat);
        check("vec_latency", 64'(lat), 64'(2));
        check("vec_a_data", 64'(a_out_data), 64'(ea));
        check("vec_a_sat",  64'(a_out_sat),  64'(sa));
        check("vec_b_data", 64'(b_out_data), 64'(eb));
        check("vec_b_sat",  64'(b_out_sat),  64'(sb));
        check("vec_c_data", 64'(c_out_data), 64'(ec));
        check("vec_c_sat",  64'(c_out_sat),  64'(sc));
        @(posedge clk); #1;
        check("vec_drained", 64'(a_out_valid), 64'(0));
    endtask

    initial begin
        int sent;
        int recv;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
`ifdef PROD_ROUND_SAT_STATS_EN
        sat_clr   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(a_out_valid), 64'(0));
        check("rst_out_data",  64'(a_out_data),  64'(0));
        check("rst_out_sat",   64'(a_out_sat),   64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(a_in_ready), 64'(1));
`ifdef PROD_ROUND_SAT_STATS_EN
        check("rst_sat_count", 64'(a_sat_count), 64'(0));
`endif

        // Rounding boundaries, wide-sum carry and narrow-output saturation.
        run_vec(64'h0000_0001_8000_0000, 32'h2, 1'b0, 32'h1, 1'b0, 16'hFFFF, 1'b1);
        run_vec(64'h0000_0001_7FFF_FFFF, 32'h1, 1'b0, 32'h1, 1'b0, 16'hFFFF, 1'b1);
        run_vec(64'h0000_0000_FFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b0, 16'hFFFF, 1'b1);
        run_vec(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0, 16'hFFFF, 1'b1);
        run_vec(64'h0000_0000_7FFF_FFFF, 32'h0, 1'b0, 32'h0, 1'b0, 16'hFFFF, 1'b1);
        run_vec(64'h0000_0000_8000_0000, 32'h1, 1'b0, 32'h0, 1'b0, 16'hFFFF, 1'b1);
        run_vec(64'h0000_0000_0000_FFFF, 32'h0, 1'b0, 32'h0, 1'b0, 16'hFFFF, 1'b0);
        run_vec(64'h0000_0000_0001_0000, 32'h0, 1'b0, 32'h0, 1'b0, 16'hFFFF, 1'b1);
        run_vec(64'h0000_0000_0000_1234, 32'h0, 1'b0, 32'h0, 1'b0, 16'h1234, 1'b0);

        // Backpressure: stream 1..5, consumer stalled for the first 4 cycles.
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 25 && recv < 5; cyc++) begin
            out_ready = (cyc >= 4);
            in_valid  = (sent < 5);
            in_data   = 64'(sent + 1) << 32;
            #1;
            if (cyc == 2 || cyc == 3) begin
                check("bp_in_ready_low", 64'(a_in_ready), 64'(0));
                check("bp_accepted", 64'(sent), 64'(2));
            end
            if (cyc >= 4) begin
                check("bp_no_gap", 64'(a_out_valid), 64'(1));
            end
            if (a_out_valid && out_ready) begin
                $display("bp cyc=%0d out=%08h", cyc, a_out_data);
                check("bp_order", 64'(a_out_data), 64'(recv + 1));
                recv++;
            end
            if (in_valid && a_in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_recv_count", 64'(recv), 64'(5));
        @(posedge clk); #1;

        // Reset while both stages hold stalled items.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h0000_0007_0000_0000;
        @(posedge clk); #1;
        in_data   = 64'h0000_0008_0000_0000;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        check("stall_full_ready", 64'(a_in_ready), 64'(0));
        check("stall_full_valid", 64'(a_out_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset out_valid=%0b out_data=%08h c_sat=%0b", a_out_valid, a_out_data, c_out_sat);
        check("arst_out_valid", 64'(a_out_valid), 64'(0));
        check("arst_out_data",  64'(a_out_data),  64'(0));
        check("arst_c_sat",     64'(c_out_sat),   64'(0));
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", 64'(a_in_ready), 64'(1));
        check("post_rst_valid", 64'(a_out_valid), 64'(0));
        run_vec(64'h0000_0003_0000_0000, 32'h3, 1'b0, 32'h3, 1'b0, 16'hFFFF, 1'b1);

`ifdef PROD_ROUND_SAT_STATS_EN
        check("stats_after_reset", 64'(a_sat_count), 64'(0));
        in_valid = 1'b1;
        in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        repeat (3) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        $display("stats three sats count=%0d", a_sat_count);
        check("stats_three", 64'(a_sat_count), 64'(3));

        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("stats_fourth_valid", 64'(a_out_valid), 64'(1));
        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        $display("stats clear vs increment count=%0d", a_sat_count);
        check("stats_clear_wins", 64'(a_sat_count), 64'(0));

        in_valid = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        $display("stats 70000 sats count=%04h", a_sat_count);
        check("stats_sticky", 64'(a_sat_count), 64'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
